// File: rtl/uc_defs.sv
// Shared encodings for the uCode CPU datapath: stack-effect codes, ALU opcodes,
// the internal shift-stack control and the canonical boolean cell values.
package uc_defs;

    typedef enum logic [2:0] {
        NO_SE    = 3'd0,
        DROP     = 3'd1,
        PUSH     = 3'd2,
        RPLC     = 3'd3,
        SWAP     = 3'd4,
        OVER     = 3'd5,
        ROT      = 3'd6,
        POP_RPLC = 3'd7
    } d_se_e;

    typedef enum logic [3:0] {
        NO_OP = 4'd0,
        ADD   = 4'd1,
        SUB   = 4'd2,
        NOT   = 4'd3,
        AND   = 4'd4,
        XOR   = 4'd5,
        OR    = 4'd6,
        ROL   = 4'd7,
        ROR   = 4'd8,
        INC   = 4'd9,
        DEC   = 4'd10,
        LSL   = 4'd11,
        LSR   = 4'd12,
        ASR   = 4'd13,
        NEG   = 4'd14
    } alu_op_e;

    // Whole-array movement of a shift stack; top-of-stack writes are separate.
    typedef enum logic [1:0] {
        SH_HOLD = 2'd0,
        SH_DOWN = 2'd1,
        SH_UP   = 2'd2
    } shift_e;

    localparam logic [15:0] TRUE  = 16'hFFFF;
    localparam logic [15:0] FALSE = 16'h0000;

endpackage

// File: rtl/uc_lifo.sv
// Depth-parameterised shift-register stack. Entry 0 is the top; the array moves
// as a whole, then the top and optionally the next two cells are overwritten.
module uc_lifo
    import uc_defs::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  shift_e           i_shift,
    input  logic             i_wr0,
    input  logic [WIDTH-1:0] i_s0_data,
    input  logic             i_wr12,
    input  logic [WIDTH-1:0] i_s1_data,
    input  logic [WIDTH-1:0] i_s2_data,
    output logic [WIDTH-1:0] o_s0,
    output logic [WIDTH-1:0] o_s1,
    output logic [WIDTH-1:0] o_s2
);

    logic [WIDTH-1:0] s_q [DEPTH];
    logic [WIDTH-1:0] s_d [DEPTH];

    always_comb begin
        // NOTE: the full default copy keeps every path assigned, so no latch is inferred.
        s_d = s_q;
        case (i_shift)
            SH_DOWN: begin
                for (int i = 1; i < DEPTH; i++) s_d[i] = s_q[i-1];
            end
            SH_UP: begin
                for (int i = 0; i < DEPTH - 1; i++) s_d[i] = s_q[i+1];
                s_d[DEPTH-1] = '0;
            end
            default: ;
        endcase
        if (i_wr0) s_d[0] = i_s0_data;
        if (i_wr12) begin
            for (int i = 1; i < DEPTH && i < 3; i++) s_d[i] = (i == 1) ? i_s1_data : i_s2_data;
        end
    end

    // NOTE: every cell is reset, not just the top, because pops expose deeper
    // entries and an empty stack must read back as zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) s_q[i] <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign o_s0 = s_q[0];
    assign o_s1 = s_q[1];

    generate
        if (DEPTH > 2) begin : g_s2_tap
            assign o_s2 = s_q[2];
        end else begin : g_s2_zero
            assign o_s2 = '0;
        end
    endgenerate

endmodule

// File: rtl/uc_stack_alu.sv
// uCode CPU datapath core: data stack with stack-effect decode, return stack
// with push/pop control, and a one-cycle registered ALU.
module uc_stack_alu
    import uc_defs::*;
#(
    parameter int WIDTH   = 16,
    parameter int D_DEPTH = 12,
    parameter int R_DEPTH = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d_data,
    input  logic [2:0]       i_d_se,
    output logic [WIDTH-1:0] o_d0,
    output logic [WIDTH-1:0] o_d1,
    input  logic [WIDTH-1:0] i_r_data,
    input  logic             i_r_push,
    input  logic             i_r_pop,
    output logic [WIDTH-1:0] o_r0,
    output logic [WIDTH-1:0] o_r1,
    input  logic [3:0]       i_alu_op,
    input  logic [WIDTH-1:0] i_alu_arg0,
    input  logic [WIDTH-1:0] i_alu_arg1,
    output logic [WIDTH-1:0] o_alu_data
);

    shift_e           d_shift;
    logic             d_wr0, d_wr12;
    logic [WIDTH-1:0] d_s0_data, d_s1_data, d_s2_data;
    logic [WIDTH-1:0] d2;

    always_comb begin
        d_shift   = SH_HOLD;
        d_wr0     = 1'b0;
        d_wr12    = 1'b0;
        d_s0_data = i_d_data;
        d_s1_data = o_d1;
        d_s2_data = d2;
        case (d_se_e'(i_d_se))
            DROP:     d_shift = SH_UP;
            PUSH:     begin d_shift = SH_DOWN; d_wr0 = 1'b1; end
            RPLC:     d_wr0 = 1'b1;
            SWAP:     begin d_wr0 = 1'b1; d_s0_data = o_d1; d_wr12 = 1'b1; d_s1_data = o_d0; end
            OVER:     begin d_shift = SH_DOWN; d_wr0 = 1'b1; d_s0_data = o_d1; end
            ROT: begin
                d_wr0     = 1'b1;
                d_s0_data = d2;
                d_wr12    = 1'b1;
                d_s1_data = o_d0;
                d_s2_data = o_d1;
            end
            POP_RPLC: begin d_shift = SH_UP; d_wr0 = 1'b1; end
            default: ;
        endcase
    end

    uc_lifo #(.WIDTH(WIDTH), .DEPTH(D_DEPTH)) u_d_stack (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_shift   (d_shift),
        .i_wr0     (d_wr0),
        .i_s0_data (d_s0_data),
        .i_wr12    (d_wr12),
        .i_s1_data (d_s1_data),
        .i_s2_data (d_s2_data),
        .o_s0      (o_d0),
        .o_s1      (o_d1),
        .o_s2      (d2)
    );

    shift_e           r_shift;
    logic             r_wr0;
    logic [WIDTH-1:0] r2;

    always_comb begin
        r_shift = SH_HOLD;
        r_wr0   = 1'b0;
        if (i_r_push && !i_r_pop) begin
            r_shift = SH_DOWN;
            r_wr0   = 1'b1;
        end else if (i_r_pop && !i_r_push) begin
            r_shift = SH_UP;
        end else if (i_r_push && i_r_pop) begin
            r_wr0 = 1'b1;
        end
    end

    // The return stack never rewrites s1/s2, so its own taps are fed back as hold values.
    uc_lifo #(.WIDTH(WIDTH), .DEPTH(R_DEPTH)) u_r_stack (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_shift   (r_shift),
        .i_wr0     (r_wr0),
        .i_s0_data (i_r_data),
        .i_wr12    (1'b0),
        .i_s1_data (o_r1),
        .i_s2_data (r2),
        .o_s0      (o_r0),
        .o_s1      (o_r1),
        .o_s2      (r2)
    );

    logic [WIDTH-1:0] alu_d, alu_q;
    logic [WIDTH-1:0] a, b;

    assign a = i_alu_arg0;
    assign b = i_alu_arg1;

    always_comb begin
        alu_d = '0;
        case (alu_op_e'(i_alu_op))
            NO_OP: alu_d = a;
            ADD:   alu_d = a + b;
            SUB:   alu_d = a - b;
            NOT:   alu_d = ~a;
            AND:   alu_d = a & b;
            XOR:   alu_d = a ^ b;
            OR:    alu_d = a | b;
            ROL:   alu_d = {a[WIDTH-2:0], a[WIDTH-1]};
            ROR:   alu_d = {a[0], a[WIDTH-1:1]};
            INC:   alu_d = a + WIDTH'(1);
            DEC:   alu_d = a - WIDTH'(1);
            LSL:   alu_d = {a[WIDTH-2:0], 1'b0};
            LSR:   alu_d = {1'b0, a[WIDTH-1:1]};
            ASR:   alu_d = {a[WIDTH-1], a[WIDTH-1:1]};
            NEG:   alu_d = WIDTH'(0) - a;
            default: alu_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so all registers sample together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) alu_q <= '0;
        else          alu_q <= alu_d;
    end

    assign o_alu_data = alu_q;

endmodule

// File: tb/tb_uc_stack_alu.sv
// Directed self-checking bench for uc_stack_alu with hand-computed expectations.
module tb_uc_stack_alu;
    import uc_defs::*;

    localparam int W = 16;
    localparam int D = 12;
    localparam int R = 12;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] d_data;
    logic [2:0]   d_se;
    logic [W-1:0] d0, d1;
    logic [W-1:0] r_data;
    logic         r_push, r_pop;
    logic [W-1:0] r0, r1;
    logic [3:0]   alu_op;
    logic [W-1:0] arg0, arg1;
    logic [W-1:0] alu_data;

    int checks   = 0;
    int failures = 0;

    uc_stack_alu #(.WIDTH(W), .D_DEPTH(D), .R_DEPTH(R)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_d_data   (d_data),
        .i_d_se     (d_se),
        .o_d0       (d0),
        .o_d1       (d1),
        .i_r_data   (r_data),
        .i_r_push   (r_push),
        .i_r_pop    (r_pop),
        .o_r0       (r0),
        .o_r1       (r1),
        .i_alu_op   (alu_op),
        .i_alu_arg0 (arg0),
        .i_alu_arg1 (arg1),
        .o_alu_data (alu_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic d_op(input logic [2:0] se, input logic [W-1:0] data);
        d_se   = se;
        d_data = data;
        @(posedge clk);
        #1;
        d_se   = NO_SE;
        d_data = '0;
    endtask

    task automatic r_op(input logic push, input logic pop, input logic [W-1:0] data);
        r_push = push;
        r_pop  = pop;
        r_data = data;
        @(posedge clk);
        #1;
        r_push = 1'b0;
        r_pop  = 1'b0;
        r_data = '0;
    endtask

    task automatic alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        alu_op = op;
        arg0   = a;
        arg1   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        d_data = '0;
        d_se   = NO_SE;
        r_data = '0;
        r_push = 1'b0;
        r_pop  = 1'b0;
        alu_op = NO_OP;
        arg0   = '0;
        arg1   = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_d0", d0, 16'h0000);
        check("rst_d1", d1, 16'h0000);
        check("rst_r0", r0, 16'h0000);
        check("rst_r1", r1, 16'h0000);
        check("rst_alu", alu_data, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rel_d0", d0, 16'h0000);
        check("post_rel_r0", r0, 16'h0000);
        check("post_rel_alu", alu_data, 16'h0000);

        // PUSH / SWAP
        d_op(PUSH, 16'd5);
        d_op(PUSH, 16'd7);
        check("push_d0", d0, 16'd7);
        check("push_d1", d1, 16'd5);
        d_op(SWAP, 16'd0);
        check("swap_d0", d0, 16'd5);
        check("swap_d1", d1, 16'd7);

        // ROT / OVER
        pulse_reset();
        d_op(PUSH, 16'd1);
        d_op(PUSH, 16'd2);
        d_op(PUSH, 16'd3);
        d_op(ROT, 16'd0);
        check("rot_d0", d0, 16'd1);
        check("rot_d1", d1, 16'd3);
        d_op(OVER, 16'd0);
        check("over_d0", d0, 16'd3);
        check("over_d1", d1, 16'd1);
        d_op(DROP, 16'd0);
        d_op(DROP, 16'd0);
        check("rot_s2_d0", d0, 16'd3);
        check("rot_s2_d1", d1, 16'd2);

        // POP_RPLC, DROP on empty, RPLC
        pulse_reset();
        d_op(PUSH, 16'd9);
        d_op(PUSH, 16'd4);
        d_op(POP_RPLC, 16'd13);
        check("poprplc_d0", d0, 16'd13);
        check("poprplc_d1", d1, 16'd0);
        d_op(DROP, 16'd0);
        d_op(DROP, 16'd0);
        check("empty_drop_d0", d0, 16'd0);
        check("empty_drop_d1", d1, 16'd0);
        d_op(PUSH, 16'd1);
        d_op(PUSH, 16'd2);
        d_op(RPLC, 16'd8);
        check("rplc_d0", d0, 16'd8);
        check("rplc_d1", d1, 16'd1);

        // Return stack
        r_op(1'b1, 1'b0, 16'h0100);
        r_op(1'b1, 1'b0, 16'h0200);
        check("rpush_r0", r0, 16'h0200);
        check("rpush_r1", r1, 16'h0100);
        r_op(1'b1, 1'b1, 16'h0300);
        check("rrplc_r0", r0, 16'h0300);
        check("rrplc_r1", r1, 16'h0100);
        r_op(1'b0, 1'b1, 16'h0000);
        check("rpop_r0", r0, 16'h0100);
        check("rpop_r1", r1, 16'h0000);
        check("rstack_indep_d0", d0, 16'd8);

        // ALU: result appears only after the edge
        alu_op = NOT;
        arg0   = 16'h00FF;
        arg1   = 16'h0000;
        #1;
        check("alu_latency", alu_data, 16'h0000);
        @(posedge clk);
        #1;
        check("alu_not", alu_data, 16'hFF00);
        alu(ADD, 16'hFFFF, 16'h0001);
        check("alu_add_wrap", alu_data, 16'h0000);
        alu(SUB, 16'h0003, 16'h0005);
        check("alu_sub", alu_data, 16'hFFFE);
        alu(ROL, 16'h8001, 16'h0000);
        check("alu_rol", alu_data, 16'h0003);
        alu(ROR, 16'h8001, 16'h0000);
        check("alu_ror", alu_data, 16'hC000);
        alu(ASR, 16'h8001, 16'h0000);
        check("alu_asr", alu_data, 16'hC000);
        alu(LSR, 16'h8001, 16'h0000);
        check("alu_lsr", alu_data, 16'h4000);
        alu(LSL, 16'h8001, 16'h0000);
        check("alu_lsl", alu_data, 16'h0002);
        alu(NEG, 16'h0001, 16'h0000);
        check("alu_neg", alu_data, 16'hFFFF);
        alu(XOR, 16'h0F0F, 16'h00FF);
        check("alu_xor", alu_data, 16'h0FF0);
        alu(DEC, 16'h0000, 16'h0000);
        check("alu_dec", alu_data, 16'hFFFF);
        alu(4'd15, 16'h1234, 16'h5678);
        check("alu_op15", alu_data, 16'h0000);

        // Depth boundary: overflow discards the bottom, underflow reads zero
        pulse_reset();
        for (int v = 1; v <= D + 1; v++) d_op(PUSH, W'(v));
        check("full_d0", d0, W'(D + 1));
        check("full_d1", d1, W'(D));
        for (int i = 0; i < D - 1; i++) d_op(DROP, 16'd0);
        check("deep_d0", d0, 16'd2);
        check("deep_d1", d1, 16'd0);
        d_op(DROP, 16'd0);
        check("drained_d0", d0, 16'd0);

        // Asynchronous reset mid-operation
        d_op(PUSH, 16'h0055);
        r_op(1'b1, 1'b0, 16'h0066);
        alu(ADD, 16'h0001, 16'h0001);
        check("pre_rst_d0", d0, 16'h0055);
        check("pre_rst_r0", r0, 16'h0066);
        check("pre_rst_alu", alu_data, 16'h0002);
        rst_n = 1'b0;
        #1;
        check("async_rst_d0", d0, 16'h0000);
        check("async_rst_r0", r0, 16'h0000);
        check("async_rst_alu", alu_data, 16'h0000);
        #5;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
